// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path:
// sequencer states, opcodes, ALU op codes, mux selects and the control bundle.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       trap;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational control table: current state, opcode and handshake inputs
// map to the datapath control bundle, the next state and a retire strobe.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        run,
  input  logic        mem_ready,
  output ctrl_t       ctrl,
  output state_t      next_state,
  output logic        retire
);

  always_comb begin
    ctrl       = '0;
    next_state = state;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        if (run) begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_source = PCSRC_ALU;
          // IR and PC only load on the cycle the memory actually returns data
          if (mem_ready) begin
            ctrl.ir_write = 1'b1;
            ctrl.pc_write = 1'b1;
            next_state    = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW:    next_state = S_MEM_ADDR;
          OP_RTYPE:        next_state = S_R_EXEC;
          OP_BEQ, OP_BNE:  next_state = S_BRANCH;
          OP_J:            next_state = S_JUMP;
          OP_ADDI, OP_SLTI: next_state = S_I_EXEC;
          default:         next_state = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        next_state     = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        next_state      = S_FETCH;
        retire          = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_RTYPE;
        next_state     = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        next_state     = S_FETCH;
        retire         = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = (opcode == OP_BNE);
        next_state         = S_FETCH;
        retire             = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        next_state     = S_FETCH;
        retire         = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        next_state     = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        next_state     = S_FETCH;
        retire         = 1'b1;
      end
      S_TRAP: begin
        ctrl.trap  = 1'b1;
        next_state = S_TRAP;
      end
      default: next_state = S_TRAP;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control sequencer: holds the state register and the
// retired-instruction counter around the combinational control table.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [5:0]       opcode_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             branch_ne_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             mem_to_reg_o,
  output logic             reg_dst_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic             trap_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  state_t           state;
  state_t           next_state;
  ctrl_t            ctrl;
  ctrl_t            ctrl_gated;
  logic             retire;
  logic [CNT_W-1:0] retired;

  ctrl_decode u_decode (
    .state      (state),
    .opcode     (opcode_i),
    .run        (run_i),
    .mem_ready  (mem_ready_i),
    .ctrl       (ctrl),
    .next_state (next_state),
    .retire     (retire)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= next_state;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // FETCH with run_i high would otherwise strobe memory while reset is held
  assign ctrl_gated = rst_i ? ctrl : '0;

  assign pc_write_o      = ctrl_gated.pc_write;
  assign pc_write_cond_o = ctrl_gated.pc_write_cond;
  assign branch_ne_o     = ctrl_gated.branch_ne;
  assign i_or_d_o        = ctrl_gated.i_or_d;
  assign mem_read_o      = ctrl_gated.mem_read;
  assign mem_write_o     = ctrl_gated.mem_write;
  assign ir_write_o      = ctrl_gated.ir_write;
  assign mem_to_reg_o    = ctrl_gated.mem_to_reg;
  assign reg_dst_o       = ctrl_gated.reg_dst;
  assign reg_write_o     = ctrl_gated.reg_write;
  assign alu_src_a_o     = ctrl_gated.alu_src_a;
  assign alu_src_b_o     = ctrl_gated.alu_src_b;
  assign alu_op_o        = ctrl_gated.alu_op;
  assign pc_source_o     = ctrl_gated.pc_source;
  assign trap_o          = ctrl_gated.trap;
  assign state_o         = state;
  assign retired_o       = retired;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy control sequencer for the multi-cycle version of the MIPS-subset CPU, with one shared memory, a single ALU and an instruction register (IR).
- Walks each instruction through fetch, decode, execute, memory and writeback states, driving every datapath select/enable each cycle.
- Supports memory wait states (mem_ready_i), run/stop gating and an illegal-opcode trap.
- Counts retired instructions for the bench.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
run_i  in  1  1 = allow new instruction fetch; sampled only in FETCH
opcode_i  in  6  IR[31:26]; valid from DECODE onward (IR registered externally)
mem_ready_i  in  1  memory access completes this cycle
pc_write_o  out  1  unconditional PC load
pc_write_cond_o  out  1  PC load if branch condition holds (datapath ANDs with zero / ~zero)
branch_ne_o  out  1  1 = condition is ~zero (bne), 0 = zero (beq)
i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read_o  out  1  memory read strobe
mem_write_o  out  1  memory write strobe
ir_write_o  out  1  IR load
mem_to_reg_o  out  1  writeback data: 0 = ALUOut, 1 = MDR
reg_dst_o  out  1  0 = rt, 1 = rd
reg_write_o  out  1  register file write
alu_src_a_o  out  1  0 = PC, 1 = A (rs)
alu_src_b_o  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
alu_op_o  out  3  ALU_ADD / ALU_SUB / ALU_RTYPE / ALU_SLT (to ALU_Ctrl)
pc_source_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
trap_o  out  1  illegal opcode seen; sticky
state_o  out  4  current state, debug
retired_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_i = 0, async): state = FETCH, retired_o = 0, trap_o = 0. All outputs are 0 while rst_i = 0, regardless of run_i. Reset mid-instruction abandons it without retiring.
- Every output not listed for a state is 0.
- Supported opcodes: R = 0x00, j = 0x02, beq = 0x04, bne = 0x05, addi = 0x08, slti = 0x0A, lw = 0x23, sw = 0x2B. Any other opcode goes to TRAP.
- FETCH (0):
  - If run_i = 0: idle, no strobes, stay.
  - Else: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = ADD, pc_source = 00.
  - ir_write and pc_write are asserted combinationally only when mem_ready_i = 1; then go to DECODE. Otherwise stay, holding mem_read.
- DECODE (1): alu_src_a = 0, alu_src_b = 11, ALU_ADD (precomputes branch target). Next state by opcode:
  - lw/sw → MEM_ADDR
  - R → R_EXEC
  - beq/bne → BRANCH
  - j → JUMP
  - addi/slti → I_EXEC
  - other → TRAP
- MEM_ADDR (2): a = 1, b = 10, ADD. lw → MEM_RD; sw → MEM_WR.
- MEM_RD (3): mem_read, i_or_d = 1. Stay until mem_ready_i, then MEM_WB.
- MEM_WB (4): reg_dst = 0, mem_to_reg = 1, reg_write → FETCH.
- MEM_WR (5): mem_write, i_or_d = 1. Stay until mem_ready_i, then FETCH. mem_write holds high through wait cycles.
- R_EXEC (6): a = 1, b = 00, ALU_RTYPE → R_WB.
- R_WB (7): reg_dst = 1, reg_write → FETCH.
- BRANCH (8): a = 1, b = 00, ALU_SUB, pc_write_cond, pc_source = 01, branch_ne = (opcode == bne) → FETCH.
- JUMP (9): pc_write, pc_source = 10 → FETCH.
- I_EXEC (10): a = 1, b = 10, alu_op = SLT for slti, ADD for addi → I_WB.
- I_WB (11): reg_dst = 0, reg_write → FETCH.
- TRAP (12): trap_o = 1, all strobes 0. Exit only by reset. Unused encodings 13–15 also go to TRAP.
- Retirement: retired_o increments by 1 on every transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or I_WB. It wraps modulo 2^CNT_W.
- Latency with mem_ready_i = 1 throughout (cycles FETCH → next FETCH): beq/bne/j = 3; R/addi/slti/sw = 4; lw = 5. Each memory wait cycle adds 1.
- run_i deasserted mid-instruction has no effect until the next FETCH.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - State encodings (FETCH … TRAP).
  - Opcode constants (OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW).
  - ALU op codes: ALU_ADD = 000, ALU_SUB = 001, ALU_RTYPE = 010, ALU_SLT = 011.
  - alu_src_b and pc_source encodings.
- One sub-module, ctrl_decode: a purely combinational state + opcode + mem_ready_i → outputs/next-state table. The top-level module holds the state register and retired counter.

Test Plan:
- Reset then run_i = 1, mem_ready_i = 1, opcode 0x00 → states 0,1,6,7,0; reg_dst = 1 and reg_write in state 7; retired_o = 1 after 4 cycles.
- lw (0x23) with mem_ready_i low for 2 cycles in MEM_RD → 7 cycles total; mem_read held; mem_to_reg = 1 only in state 4; retired_o increments once.
- bne (0x05) → state 8 with pc_write_cond = 1, branch_ne_o = 1, pc_source = 01, alu_op = 001; 3 cycles.
- run_i = 0 in FETCH for 5 cycles → no mem_read, state_o = 0, retired_o unchanged; raise run_i → fetch proceeds.
- opcode 0x3F at DECODE → state 12, trap_o = 1 sticky for 20 cycles with all strobes 0; rst_i low → state 0, trap_o = 0, retired_o = 0.
- Assert rst_i low asynchronously mid-MEM_WR → outputs drop to 0 immediately; after release state_o = 0, retired_o = 0.
